// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 geometry, coordinate width and
// a per-axis timing-set type so other modes reuse the same generator via overrides.
package vga_pkg;

    localparam int unsigned CW = 12;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    localparam timing_t H_640X480 = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam timing_t V_640X480 = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam timing_t H_800X600 = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam timing_t V_800X600 = '{active: 600, fp: 1,  sync: 4,   bp: 23};

    function automatic int unsigned axis_total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with carry-out, plus active-region and sync-window decodes.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned W = CW,
    parameter timing_t     T = H_640X480
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         carry,
    output logic         active,
    output logic         in_sync
);

    localparam int unsigned  TOTAL      = axis_total(T);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(T.active);
    localparam logic [W-1:0] SYNC_START = W'(T.active + T.fp);
    localparam logic [W-1:0] SYNC_END   = W'(T.active + T.fp + T.sync);

    logic [W-1:0] cnt_d, cnt_q;
    logic         at_last;

    assign at_last = (cnt_q == LAST);
    assign carry   = inc && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign active  = (cnt_q < ACT_END);
    assign in_sync = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel coordinates, data-enable, syncs and line/frame
// strobes, all registered one cycle after the counters so they describe the same pixel.
module vga_timing #(
    parameter int unsigned H_ACTIVE = vga_pkg::H_640X480.active,
    parameter int unsigned H_FP     = vga_pkg::H_640X480.fp,
    parameter int unsigned H_SYNC   = vga_pkg::H_640X480.sync,
    parameter int unsigned H_BP     = vga_pkg::H_640X480.bp,
    parameter int unsigned V_ACTIVE = vga_pkg::V_640X480.active,
    parameter int unsigned V_FP     = vga_pkg::V_640X480.fp,
    parameter int unsigned V_SYNC   = vga_pkg::V_640X480.sync,
    parameter int unsigned V_BP     = vga_pkg::V_640X480.bp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = vga_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] hdata,
    output logic [CW-1:0] vdata,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    import vga_pkg::*;

    localparam timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_carry, v_carry;
    logic          h_active, v_active;
    logic          h_in_sync, v_in_sync;
    logic          origin_q;

    vga_axis_counter #(
        .W (CW),
        .T (H_T)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .inc     (en),
        .cnt     (h_cnt),
        .carry   (h_carry),
        .active  (h_active),
        .in_sync (h_in_sync)
    );

    vga_axis_counter #(
        .W (CW),
        .T (V_T)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .inc     (h_carry),
        .cnt     (v_cnt),
        .carry   (v_carry),
        .active  (v_active),
        .in_sync (v_in_sync)
    );

    // Counters sit at (0,0) only after reset or a full-frame wrap, so track that
    // directly instead of decoding both counters for the frame strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            origin_q <= 1'b1;
        end else if (en) begin
            origin_q <= v_carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdata       <= '0;
            vdata       <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hdata       <= h_cnt;
            vdata       <= v_cnt;
            de          <= h_active && v_active;
            hsync       <= h_in_sync ? HS_POL : ~HS_POL;
            vsync       <= v_in_sync ? VS_POL : ~VS_POL;
            line_start  <= (h_cnt == '0);
            frame_start <= origin_q;
        end else begin
            // Levels hold while stalled; strobes must not stretch.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
